// File: rtl/ir_key_controller_pkg.sv
// Shared SIRC frame layout and key-controller state encoding.
package ir_key_controller_pkg;

    localparam int unsigned CMD_W    = 7;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ADDR_LSB = 7;
    localparam int unsigned FRAME_W  = CMD_W + ADDR_W;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StConfirm = 2'd1,
        StHeld    = 2'd2
    } key_state_e;

    function automatic logic [CMD_W-1:0] frame_cmd(input logic [FRAME_W-1:0] frame);
        return frame[CMD_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] frame);
        return frame[ADDR_LSB +: ADDR_W];
    endfunction

endpackage

// File: rtl/ir_key_controller_if.sv
// Frame input from ir_receiver and key-event outputs to the application.
interface ir_key_controller_if;
    import ir_key_controller_pkg::*;

    logic [FRAME_W-1:0] data;
    logic               data_rdy;
    logic [CMD_W-1:0]   cmd;
    logic [ADDR_W-1:0]  addr;
    logic               cmd_valid;
    logic               cmd_repeat;
    logic               key_held;
    logic               key_released;

    // Drives frames, observes key events.
    modport master (
        output data, data_rdy,
        input  cmd, addr, cmd_valid, cmd_repeat, key_held, key_released
    );

    // The key controller itself.
    modport slave (
        input  data, data_rdy,
        output cmd, addr, cmd_valid, cmd_repeat, key_held, key_released
    );

endinterface

// File: rtl/ir_gap_detector.sv
// Synchronizes the raw IR line and flags end of frame after a long idle-high gap.
module ir_gap_detector #(
    parameter int unsigned GAP_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ir_in,
    output logic frame_end
);

    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             armed_q, armed_d;
    logic             frame_end_q, frame_end_d;

    // Gap counter clears on a low, saturates while idle; pulse on first arrival at the limit.
    always_comb begin
        gap_d       = gap_q;
        armed_d     = armed_q;
        frame_end_d = 1'b0;
        if (!sync2_q) begin
            gap_d   = '0;
            armed_d = 1'b1;
        end else if (gap_q != GAP_SAT) begin
            gap_d = gap_q + GAP_W'(1);
        end
        // armed suppresses the spurious gap that follows reset on an idle line
        frame_end_d = armed_q && sync2_q && (gap_q == GAP_LAST);
    end

    // Synchronizer (resets to idle-high) and gap state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            gap_q       <= '0;
            armed_q     <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            sync1_q     <= ir_in;
            sync2_q     <= sync1_q;
            gap_q       <= gap_d;
            armed_q     <= armed_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign frame_end = frame_end_q;

endmodule

// File: rtl/ir_key_controller.sv
// Turns SIRC frames into debounced press / auto-repeat / release key events.
module ir_key_controller
    import ir_key_controller_pkg::*;
#(
    parameter int unsigned       GAP_CYCLES           = 100000,
    parameter int unsigned       CONFIRM_FRAMES       = 2,
    parameter int unsigned       RELEASE_CYCLES       = 3000000,
    parameter int unsigned       REPEAT_START_CYCLES  = 25000000,
    parameter int unsigned       REPEAT_PERIOD_CYCLES = 5000000,
    parameter bit                ADDR_FILTER_EN       = 1'b1,
    parameter logic [ADDR_W-1:0] ADDR_FILTER          = 5'h01
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ir_in,
    ir_key_controller_if.slave bus
);

    localparam int unsigned CNT_W   = $clog2(CONFIRM_FRAMES + 1);
    localparam int unsigned REL_W   = $clog2(RELEASE_CYCLES + 1);
    localparam int unsigned REP_MAX = (REPEAT_START_CYCLES > REPEAT_PERIOD_CYCLES) ?
                                      REPEAT_START_CYCLES : REPEAT_PERIOD_CYCLES;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0] CONFIRM_N       = CNT_W'(CONFIRM_FRAMES);
    localparam logic [REL_W-1:0] REL_SAT         = REL_W'(RELEASE_CYCLES);
    localparam logic [REL_W-1:0] REL_LAST        = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_START_LAST  = REP_W'(REPEAT_START_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);

    key_state_e         state_q, state_d;
    logic [FRAME_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [REL_W-1:0]   rel_q, rel_d;
    logic [REP_W-1:0]   rep_q, rep_d, rep_limit;
    logic               rep_first_q, rep_first_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_repeat_q, cmd_repeat_d;
    logic               key_released_q, key_released_d;

    logic frame_end;
    logic frame_evt, addr_ok, accept, match;
    logic rel_hit, rep_hit, do_confirm;

    ir_gap_detector #(
        .GAP_CYCLES (GAP_CYCLES)
    ) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .ir_in     (ir_in),
        .frame_end (frame_end)
    );

    assign frame_evt = frame_end & bus.data_rdy;
    assign addr_ok   = !ADDR_FILTER_EN || (frame_addr(bus.data) == ADDR_FILTER);
    assign accept    = frame_evt & addr_ok;
    assign match     = accept & (bus.data == cand_q);
    assign cnt_inc   = cnt_q + CNT_W'(1);

    // First repeat waits the long start delay, later ones the shorter period.
    assign rep_limit = rep_first_q ? REP_START_LAST : REP_PERIOD_LAST;
    assign rel_hit   = (state_q != StIdle) && (rel_q == REL_LAST);
    assign rep_hit   = (state_q == StHeld) && (rep_q == rep_limit);

    // Next-state, timers and registered event outputs.
    always_comb begin
        state_d        = state_q;
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        rel_d          = rel_q;
        rep_d          = '0;
        rep_first_d    = rep_first_q;
        cmd_d          = cmd_q;
        addr_d         = addr_q;
        cmd_valid_d    = 1'b0;
        cmd_repeat_d   = 1'b0;
        key_released_d = 1'b0;
        do_confirm     = 1'b0;

        if ((state_q != StIdle) && (rel_q != REL_SAT)) begin
            rel_d = rel_q + REL_W'(1);
        end
        if (state_q == StHeld) begin
            rep_d = rep_q + REP_W'(1);
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    cand_d = bus.data;
                    cnt_d  = CNT_W'(1);
                    rel_d  = '0;
                    if (CONFIRM_FRAMES == 1) begin
                        do_confirm = 1'b1;
                    end else begin
                        state_d = StConfirm;
                    end
                end
            end
            StConfirm: begin
                if (match) begin
                    rel_d = '0;
                    cnt_d = cnt_inc;
                    if (cnt_inc == CONFIRM_N) begin
                        do_confirm = 1'b1;
                    end
                end else if (accept) begin
                    cand_d = bus.data;
                    cnt_d  = CNT_W'(1);
                    rel_d  = '0;
                end else if (rel_hit) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    rel_d   = '0;
                end
            end
            StHeld: begin
                if (accept && !match) begin
                    // a different key takes over: release the old one first
                    key_released_d = 1'b1;
                    cand_d         = bus.data;
                    cnt_d          = CNT_W'(1);
                    rel_d          = '0;
                    if (CONFIRM_FRAMES == 1) begin
                        do_confirm = 1'b1;
                    end else begin
                        state_d = StConfirm;
                    end
                end else if (!match && rel_hit) begin
                    // timeout outranks a repeat due in the same cycle
                    key_released_d = 1'b1;
                    state_d        = StIdle;
                    cnt_d          = '0;
                    rel_d          = '0;
                end else begin
                    if (match) begin
                        rel_d = '0;
                    end
                    if (rep_hit) begin
                        cmd_valid_d  = 1'b1;
                        cmd_repeat_d = 1'b1;
                        rep_d        = '0;
                        rep_first_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (do_confirm) begin
            cmd_valid_d  = 1'b1;
            cmd_repeat_d = 1'b0;
            cmd_d        = frame_cmd(bus.data);
            addr_d       = frame_addr(bus.data);
            state_d      = StHeld;
            rep_d        = '0;
            rep_first_d  = 1'b1;
        end
    end

    // State and output registers; reset aborts silently with no release pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            cand_q         <= '0;
            cnt_q          <= '0;
            rel_q          <= '0;
            rep_q          <= '0;
            rep_first_q    <= 1'b0;
            cmd_q          <= '0;
            addr_q         <= '0;
            cmd_valid_q    <= 1'b0;
            cmd_repeat_q   <= 1'b0;
            key_released_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            rel_q          <= rel_d;
            rep_q          <= rep_d;
            rep_first_q    <= rep_first_d;
            cmd_q          <= cmd_d;
            addr_q         <= addr_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_repeat_q   <= cmd_repeat_d;
            key_released_q <= key_released_d;
        end
    end

    assign bus.cmd          = cmd_q;
    assign bus.addr         = addr_q;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_repeat   = cmd_repeat_q;
    assign bus.key_released = key_released_q;
    assign bus.key_held     = (state_q == StHeld);

endmodule
